// File: rtl/regfile_multiport.sv
// Two-write, two-read register file with a per-register busy scoreboard and a busy count.
// Read-during-write bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              rb0,
    output logic              rb1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              rb0_q, rb0_d, rb1_q, rb1_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic              wr0_ok_c, wr1_ok_c, rsv_ok_c;

    // Next-state: writes (port 1 last so it wins), then reserve (wins over clear).
    always_comb begin
        wr0_ok_c = we0 && !((ZERO_REG != 0) && (wa0 == '0));
        wr1_ok_c = we1 && !((ZERO_REG != 0) && (wa1 == '0));
        rsv_ok_c = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
        mem_d    = mem_q;
        busy_d   = busy_q;
        if (wr0_ok_c) begin
            mem_d[wa0]  = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (wr1_ok_c) begin
            mem_d[wa1]  = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (rsv_ok_c) begin
            busy_d[rsv_addr] = 1'b1;
        end

        busy_cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end

`ifdef REGFILE_BYPASS_EN
        rd0_d = mem_d[ra0];
        rd1_d = mem_d[ra1];
`else
        rd0_d = mem_q[ra0];
        rd1_d = mem_q[ra1];
`endif
        rb0_d = busy_d[ra0];
        rb1_d = busy_d[ra1];
        if ((ZERO_REG != 0) && (ra0 == '0)) begin
            rd0_d = '0;
            rb0_d = 1'b0;
        end
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            rd1_d = '0;
            rb1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            rd0_q      <= '0;
            rd1_q      <= '0;
            rb0_q      <= 1'b0;
            rb1_q      <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
            rb0_q      <= rb0_d;
            rb1_q      <= rb1_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rd0      = rd0_q;
    assign rd1      = rd1_q;
    assign rb0      = rb0_q;
    assign rb1      = rb1_q;
    assign busy_cnt = busy_cnt_q;

endmodule
